rv32_lsu: RTL and testbench

- Load/store execution unit for the RV32I core.
- Consumes the memory-operation control produced by instruction decode: mem_op encodes LB/LH/LW/LBU/LHU for loads and SB/SH/SW for stores; mem_wr selects a store.
- Performs the data-memory handshake, generates byte strobes, and returns the aligned, sign- or zero-extended load result for register writeback.

---
 rtl/rv32_lsu.sv | 278 +++++++++++++++++++++++++++
 tb/tb_rv32_lsu.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv32_lsu.sv
// ---------------------------------------------------------------------------
// rv32_lsu : load/store execution unit for the RV32I core.
//
// Accepts one memory operation at a time from decode, runs the data-bus
// handshake, produces byte strobes and lane-replicated store data, and returns
// the aligned, sign/zero-extended load value for register writeback.
//
// Ports
//   clk, rst_n        core clock, asynchronous active-low reset
//   start             one-cycle request, sampled only while idle
//   mem_wr, mem_op    1 = store; op: LB/LH/LW/LBU/LHU or SB/SH/SW
//   addr, wdata       effective byte address, store data (rs2)
//   busy              high from accept through the done cycle
//   done, fault       one-cycle completion pulse, fault qualifier
//   rdata             extended load result, valid with done
//   mem_req, mem_we   bus request (held until mem_ready), write enable
//   mem_addr          word-aligned bus address
//   mem_wstrb         byte write strobes (0000 on reads)
//   mem_wdata         lane-replicated store data
//   mem_ready         bus completion, mem_rdata valid the same cycle
//   mem_rdata         read word
//
// Optional build macro
//   LSU_TIMEOUT_EN    enables a watchdog that faults the access after
//                     TIMEOUT_CYCLES request cycles without mem_ready.
// ---------------------------------------------------------------------------
module rv32_lsu #(
  parameter int ADDR_W         = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              mem_wr,
  input  logic [2:0]        mem_op,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              busy,
  output logic              done,
  output logic              fault,
  output logic [31:0]       rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_wstrb,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ready,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_REQ   = 2'd1,
    S_DONE  = 2'd2,
    S_FAULT = 2'd3
  } state_t;

  // Access size classes shared by loads and stores.
  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  state_t state, state_nxt;

  // Request captured at accept.
  logic              wr_p0;
  logic [2:0]        op_p0;
  logic [ADDR_W-3:0] word_p0;
  logic [1:0]        lane_p0;
  logic [31:0]       wdata_p0;

  // Registered load result.
  logic [31:0]       rdata_p1;

  logic              accept;
  logic              load_cpl;

  // -------------------------------------------------------------------------
  // Decode helpers
  // -------------------------------------------------------------------------
  // LB/LBU/SB -> byte, LH/LHU/SH -> half, LW/SW -> word.
  function automatic logic [1:0] f_size(input logic [2:0] op);
    logic [1:0] sz;
    case (op)
      3'b010:         sz = SZ_WORD;
      3'b001, 3'b100: sz = SZ_HALF;
      default:        sz = SZ_BYTE;
    endcase
    return sz;
  endfunction

  function automatic logic f_illegal(input logic wr, input logic [2:0] op);
    return wr ? (op > 3'b010) : (op > 3'b100);
  endfunction

  function automatic logic f_misaligned(input logic [2:0] op, input logic [1:0] lane);
    logic [1:0] sz;
    sz = f_size(op);
    return ((sz == SZ_HALF) && lane[0]) || ((sz == SZ_WORD) && (lane != 2'b00));
  endfunction

  function automatic logic [3:0] f_strobe(input logic [2:0] op, input logic [1:0] lane);
    logic [3:0] strb;
    case (f_size(op))
      SZ_WORD: strb = 4'b1111;
      SZ_HALF: strb = 4'b0011 << {lane[1], 1'b0};
      default: strb = 4'b0001 << lane;
    endcase
    return strb;
  endfunction

  function automatic logic [31:0] f_store_data(input logic [2:0] op, input logic [31:0] wd);
    logic [31:0] rep;
    case (f_size(op))
      SZ_WORD: rep = wd;
      SZ_HALF: rep = {2{wd[15:0]}};
      default: rep = {4{wd[7:0]}};
    endcase
    return rep;
  endfunction

  // Pick the addressed lane and extend it; signed locals carry the sign bit
  // into the upper bits on assignment to the 32-bit signed result.
  function automatic logic [31:0] f_load_extract(input logic [2:0]  op,
                                                 input logic [1:0]  lane,
                                                 input logic [31:0] word);
    logic [31:0]        sh_b;
    logic [31:0]        sh_h;
    logic signed [7:0]  b_s;
    logic signed [15:0] h_s;
    logic signed [31:0] ext;
    sh_b = word >> {lane, 3'b000};
    sh_h = word >> {lane[1], 4'b0000};
    b_s  = signed'(sh_b[7:0]);
    h_s  = signed'(sh_h[15:0]);
    case (op)
      3'b000:  ext = b_s;
      3'b001:  ext = h_s;
      3'b011:  ext = signed'({24'd0, sh_b[7:0]});
      3'b100:  ext = signed'({16'd0, sh_h[15:0]});
      default: ext = signed'(word);
    endcase
    return unsigned'(ext);
  endfunction

  assign accept   = (state == S_IDLE) && start;
  assign load_cpl = (state == S_REQ) && mem_ready && !wr_p0;

  // -------------------------------------------------------------------------
  // Optional request watchdog
  // -------------------------------------------------------------------------
`ifdef LSU_TIMEOUT_EN
  localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] wait_cnt;
  logic             timed_out;

  // Cleared outside REQ so every access starts counting from zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= '0;
    end else if (state != S_REQ) begin
      wait_cnt <= '0;
    end else if (!mem_ready) begin
      wait_cnt <= wait_cnt + CNT_W'(1);
    end
  end

  // Last permitted REQ cycle with no ready; a ready on this cycle still wins
  // because the REQ branch tests mem_ready first.
  assign timed_out = (wait_cnt == CNT_LAST);
`else
  logic timed_out;
  logic unused_timeout_cfg;
  assign timed_out          = 1'b0;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
`endif

  // -------------------------------------------------------------------------
  // FSM state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // -------------------------------------------------------------------------
  // FSM next state and outputs
  // -------------------------------------------------------------------------
  // Bus outputs are gated by REQ so they read zero in every other state,
  // including reset, without resetting the captured request registers.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    fault     = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wstrb = 4'b0000;
    mem_wdata = 32'd0;
    rdata     = rdata_p1;

    case (state)
      S_IDLE: begin
        if (start) begin
          if (f_illegal(mem_wr, mem_op) || f_misaligned(mem_op, addr[1:0])) begin
            state_nxt = S_FAULT;
          end else begin
            state_nxt = S_REQ;
          end
        end
      end
      S_REQ: begin
        busy     = 1'b1;
        mem_req  = 1'b1;
        mem_we   = wr_p0;
        mem_addr = {word_p0, 2'b00};
        if (wr_p0) begin
          mem_wstrb = f_strobe(op_p0, lane_p0);
          mem_wdata = f_store_data(op_p0, wdata_p0);
        end
        if (mem_ready) begin
          state_nxt = S_DONE;
        end else if (timed_out) begin
          state_nxt = S_FAULT;
        end
      end
      S_DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      S_FAULT: begin
        busy      = 1'b1;
        done      = 1'b1;
        fault     = 1'b1;
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Stage p0: request capture at accept
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (accept) begin
      wr_p0    <= mem_wr;
      op_p0    <= mem_op;
      word_p0  <= addr[ADDR_W-1:2];
      lane_p0  <= addr[1:0];
      wdata_p0 <= wdata;
    end
  end

  // -------------------------------------------------------------------------
  // Stage p1: load result register
  // -------------------------------------------------------------------------
  // Cleared on any entry to FAULT so a faulting access reports zero; stores
  // leave the previous value in place.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_p1 <= 32'd0;
    end else if (state_nxt == S_FAULT) begin
      rdata_p1 <= 32'd0;
    end else if (load_cpl) begin
      rdata_p1 <= f_load_extract(op_p0, lane_p0, mem_rdata);
    end
  end

endmodule

// File: tb/tb_rv32_lsu.sv
// ---------------------------------------------------------------------------
// tb_rv32_lsu : self-checking bench for rv32_lsu.
// A transaction-level model derives per-cycle expected outputs from the
// access rules; a single negedge process compares them with the DUT.
// ---------------------------------------------------------------------------
module tb_rv32_lsu;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        mem_wr;
  logic [2:0]  mem_op;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        busy, done, fault;
  logic [31:0] rdata;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  rv32_lsu #(.ADDR_W(32), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mem_wr(mem_wr), .mem_op(mem_op),
    .addr(addr), .wdata(wdata), .busy(busy), .done(done), .fault(fault),
    .rdata(rdata), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata), .mem_ready(mem_ready),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Per-cycle expectations
  logic        chk_en;
  logic        e_busy, e_done, e_fault, e_req, e_we;
  logic [31:0] e_addr, e_wdata, e_rdata;
  logic [3:0]  e_strb;
  logic [31:0] model_rdata;

  // Observations recorded by the compare process
  int          cyc = 0;
  int          start_cyc = 0;
  int          done_cyc = -1;
  int          req_cnt = 0;
  logic [31:0] done_rdata;
  logic        done_fault;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_strb;
  logic        req_we;

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got 0x%08h expected 0x%08h", nm, cyc, act, exp);
    end
  endtask

  // ----- behavioural model -------------------------------------------------
  function automatic int nbytes(input logic [2:0] op);
    if (op == 3'd2) return 4;
    if (op == 3'd1 || op == 3'd4) return 2;
    return 1;
  endfunction

  function automatic bit is_bad(input logic wr, input logic [2:0] op, input logic [31:0] a);
    if (wr ? (op > 3'd2) : (op > 3'd4)) return 1'b1;
    return (a % nbytes(op)) != 0;
  endfunction

  function automatic logic [31:0] load_val(input logic [2:0] op, input logic [31:0] a,
                                           input logic [31:0] word);
    int          n;
    logic [31:0] mask, v;
    n    = nbytes(op);
    mask = (n == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * n)) - 32'd1);
    v    = (word >> (8 * (a % 4))) & mask;
    if ((op == 3'd0 || op == 3'd1) && v[8*n-1]) v = v | ~mask;
    return v;
  endfunction

  function automatic logic [3:0] strobe_of(input logic [2:0] op, input logic [31:0] a);
    logic [3:0] s;
    s = 4'((32'd1 << nbytes(op)) - 32'd1);
    return s << (a % 4);
  endfunction

  function automatic logic [31:0] wdata_of(input logic [2:0] op, input logic [31:0] w);
    if (nbytes(op) == 1) return {24'd0, w[7:0]} * 32'h0101_0101;
    if (nbytes(op) == 2) return {16'd0, w[15:0]} * 32'h0001_0001;
    return w;
  endfunction

  task automatic set_idle();
    e_busy = 0; e_done = 0; e_fault = 0; e_req = 0; e_we = 0;
    e_addr = 0; e_wdata = 0; e_strb = 0; e_rdata = 0;
  endtask

  // ----- compare process ---------------------------------------------------
  always @(negedge clk) begin
    cyc++;
    if (chk_en) begin
      cmp("busy", {31'd0, busy}, {31'd0, e_busy});
      cmp("done", {31'd0, done}, {31'd0, e_done});
      cmp("fault", {31'd0, fault}, {31'd0, e_fault});
      cmp("mem_req", {31'd0, mem_req}, {31'd0, e_req});
      cmp("mem_we", {31'd0, mem_we}, {31'd0, e_we});
      cmp("mem_addr", mem_addr, e_addr);
      cmp("mem_wstrb", {28'd0, mem_wstrb}, {28'd0, e_strb});
      cmp("mem_wdata", mem_wdata, e_wdata);
      if (e_done) cmp("rdata", rdata, e_rdata);
    end
    if (start && !busy && rst_n) begin
      start_cyc = cyc;
      req_cnt   = 0;
    end
    if (done) begin
      done_cyc   = cyc;
      done_rdata = rdata;
      done_fault = fault;
    end
    if (mem_req) begin
      req_cnt++;
      req_addr  = mem_addr;
      req_strb  = mem_wstrb;
      req_wdata = mem_wdata;
      req_we    = mem_we;
    end
  end

  // ----- driver ------------------------------------------------------------
  // Entered and left at posedge+1 of an idle cycle.
  task automatic run_txn(input logic wr, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] wd, input int waits, input logic [31:0] word,
                         input bit poke);
    bit bad;
    bad    = is_bad(wr, op, a);
    start  = 1; mem_wr = wr; mem_op = op; addr = a; wdata = wd;
    set_idle();
    @(posedge clk); #1;
    start = poke ? 1'($urandom) : 1'b0;
    mem_wr = 1'($urandom); mem_op = 3'($urandom); addr = $urandom; wdata = $urandom;
    if (bad) begin
      model_rdata = 0;
      e_busy = 1; e_done = 1; e_fault = 1; e_rdata = 0;
      @(posedge clk); #1;
    end else begin
      for (int w = 0; w <= waits; w++) begin
        e_busy = 1; e_req = 1; e_we = wr; e_addr = {a[31:2], 2'b00};
        e_strb  = wr ? strobe_of(op, a) : 4'b0000;
        e_wdata = wr ? wdata_of(op, wd) : 32'd0;
        mem_ready = (w == waits);
        mem_rdata = mem_ready ? word : $urandom;
        @(posedge clk); #1;
        start = poke ? 1'($urandom) : 1'b0;
      end
      mem_ready = 0; mem_rdata = $urandom;
      if (!wr) model_rdata = load_val(op, a, word);
      set_idle();
      e_busy = 1; e_done = 1; e_rdata = model_rdata;
      @(posedge clk); #1;
    end
    start = 0;
    set_idle();
  endtask

  task automatic launch(input logic wr, input logic [2:0] op, input logic [31:0] a);
    start = 1; mem_wr = wr; mem_op = op; addr = a; wdata = $urandom;
    @(posedge clk); #1;
    start = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 0; start = 0; mem_wr = 0; mem_op = 0; addr = 0; wdata = 0;
    mem_ready = 0; mem_rdata = 0; chk_en = 0; model_rdata = 0;
    set_idle();
    repeat (2) @(posedge clk); #1;
    cmp("rst_busy", {31'd0, busy}, 32'd0);
    cmp("rst_done", {31'd0, done}, 32'd0);
    cmp("rst_fault", {31'd0, fault}, 32'd0);
    cmp("rst_mem_req", {31'd0, mem_req}, 32'd0);
    cmp("rst_mem_we", {31'd0, mem_we}, 32'd0);
    cmp("rst_rdata", rdata, 32'd0);
    cmp("rst_mem_addr", mem_addr, 32'd0);
    cmp("rst_mem_wstrb", {28'd0, mem_wstrb}, 32'd0);
    cmp("rst_mem_wdata", mem_wdata, 32'd0);
    rst_n = 1;
    @(posedge clk); #1;
    chk_en = 1;

    // LB, upper lane, negative byte
    run_txn(0, 3'd0, 32'h103, 32'd0, 0, 32'h80FF_1234, 0);
    cmp("lb_rdata", done_rdata, 32'hFFFF_FF80);
    cmp("lb_model", model_rdata, 32'hFFFF_FF80);
    cmp("lb_addr", req_addr, 32'h100);
    cmp("lb_strb", {28'd0, req_strb}, 32'd0);
    cmp("lb_latency", done_cyc - start_cyc, 2);
    cmp("lb_fault", {31'd0, done_fault}, 32'd0);

    // LHU then LH on the same word
    run_txn(0, 3'd4, 32'h202, 32'd0, 0, 32'hBEEF_0000, 0);
    cmp("lhu_rdata", done_rdata, 32'h0000_BEEF);
    run_txn(0, 3'd1, 32'h202, 32'd0, 1, 32'hBEEF_0000, 0);
    cmp("lh_rdata", done_rdata, 32'hFFFF_BEEF);

    // SB with three wait cycles; rdata must keep the LH value
    run_txn(1, 3'd0, 32'h301, 32'h1234_56AB, 3, 32'd0, 1);
    cmp("sb_req_cycles", req_cnt, 4);
    cmp("sb_strb", {28'd0, req_strb}, 32'h2);
    cmp("sb_wdata", req_wdata, 32'hABAB_ABAB);
    cmp("sb_we", {31'd0, req_we}, 32'd1);
    cmp("sb_latency", done_cyc - start_cyc, 5);
    cmp("sb_rdata_kept", done_rdata, 32'hFFFF_BEEF);

    // SH upper half
    run_txn(1, 3'd1, 32'h306, 32'hCAFE_5678, 0, 32'd0, 0);
    cmp("sh_strb", {28'd0, req_strb}, 32'hC);
    cmp("sh_wdata", req_wdata, 32'h5678_5678);

    // Misaligned LW and illegal store op
    run_txn(0, 3'd2, 32'h402, 32'd0, 0, 32'd0, 0);
    cmp("lw_mis_latency", done_cyc - start_cyc, 1);
    cmp("lw_mis_fault", {31'd0, done_fault}, 32'd1);
    cmp("lw_mis_req", req_cnt, 0);
    cmp("lw_mis_rdata", done_rdata, 32'd0);
    run_txn(1, 3'd3, 32'h400, 32'h1111_2222, 0, 32'd0, 0);
    cmp("st_ill_latency", done_cyc - start_cyc, 1);
    cmp("st_ill_fault", {31'd0, done_fault}, 32'd1);
    cmp("st_ill_req", req_cnt, 0);

    // Randomized traffic
    for (int i = 0; i < 300; i++) begin
      logic        wr;
      logic [2:0]  op;
      logic [31:0] a;
      wr = 1'($urandom);
      op = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'($urandom_range(0, wr ? 2 : 4));
      a  = $urandom;
      if ($urandom_range(0, 1) == 0) a[1:0] = 2'b00;
      run_txn(wr, op, a, $urandom, $urandom_range(0, 4), $urandom, 1'($urandom));
    end

    // Reset in the middle of a waiting request
    chk_en = 0;
    launch(0, 3'd2, 32'h500);
    repeat (2) @(posedge clk);
    #3;
    rst_n = 0;
    #1;
    cmp("midrst_mem_req", {31'd0, mem_req}, 32'd0);
    cmp("midrst_busy", {31'd0, busy}, 32'd0);
    cmp("midrst_done", {31'd0, done}, 32'd0);
    cmp("midrst_mem_addr", mem_addr, 32'd0);
    cmp("midrst_rdata", rdata, 32'd0);
    @(posedge clk); #1;
    rst_n = 1;
    model_rdata = 0;
    set_idle();
    @(posedge clk); #1;
    chk_en = 1;
    for (int i = 0; i < 20; i++) begin
      run_txn(1'($urandom), 3'($urandom_range(0, 2)), $urandom & 32'hFFFF_FFFC,
              $urandom, $urandom_range(0, 3), $urandom, 1'b1);
    end

    // Ready held low
    chk_en = 0;
    mem_ready = 0;
    done_cyc = -1;
    launch(0, 3'd2, 32'h600);
`ifdef LSU_TIMEOUT_EN
    for (int i = 0; i < 40 && done_cyc < start_cyc; i++) @(posedge clk);
    #1;
    cmp("to_latency", done_cyc - start_cyc, TO + 1);
    cmp("to_fault", {31'd0, done_fault}, 32'd1);
    cmp("to_req_cycles", req_cnt, TO);
    cmp("to_rdata", done_rdata, 32'd0);
    cmp("to_req_after", {31'd0, mem_req}, 32'd0);
`else
    repeat (100) @(posedge clk);
    #1;
    cmp("noto_done_seen", {31'd0, (done_cyc >= start_cyc)}, 32'd0);
    cmp("noto_req_held", {31'd0, mem_req}, 32'd1);
    rst_n = 0;
    #1;
    cmp("noto_rst_req", {31'd0, mem_req}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
